// File: rtl/powlib_lvlfifo.sv
// powlib_lvlfifo: first-word-fall-through FIFO with registered level flags
// (wrrdy, rdvld, afull, aempty all decoded from the next occupancy).
// Optional high-watermark output enabled by defining POWLIB_LVLFIFO_PEAK_EN.
module powlib_lvlfifo #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int AFTH = D - 2,
  parameter int AETH = 2,
  parameter int EDBG = 0,
  parameter     ID   = "LVLFIFO",
  // powlib_clogb2(x) is ceil(log2(x)); declared here so the port list can use it
  localparam int WC  = $clog2(D + 1),
  localparam int WP  = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  input  logic          flush,
  output logic [WC-1:0] count,
`ifdef POWLIB_LVLFIFO_PEAK_EN
  output logic          afull,
  output logic          aempty,
  output logic [WC-1:0] peak,
  input  logic          peakclr
`else
  output logic          afull,
  output logic          aempty
`endif
);

  // Parameter sanity check at elaboration; stops the build when debug checks are enabled
  if (EDBG != 0 && (AFTH < 1 || AFTH > D || AETH < 0 || AETH > D - 1)) begin : g_param_chk
    $fatal(1, "%s: AFTH=%0d or AETH=%0d out of range for D=%0d", ID, AFTH, AETH, D);
  end

  logic [W-1:0]  mem [D];
  logic [WP-1:0] wrptr;
  logic [WP-1:0] rdptr;
  logic [WC-1:0] count_nxt;
  logic          wrinc;
  logic          rdinc;

  // Handshakes use only registered ready/valid, so no full- or empty-bypass exists
  assign wrinc  = wrvld & wrrdy;
  assign rdinc  = rdvld & rdrdy;
  assign rddata = mem[rdptr];

  function automatic logic [WP-1:0] ptr_inc(input logic [WP-1:0] p);
    return (p == WP'(D - 1)) ? '0 : p + WP'(1);
  endfunction

  // Next occupancy; flush overrides any transfer in the same cycle
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wrinc, rdinc})
        2'b10:   count_nxt = count + WC'(1);
        2'b01:   count_nxt = count - WC'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers, occupancy and level flags, all registered from next-count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr  <= '0;
      rdptr  <= '0;
      count  <= '0;
      wrrdy  <= 1'b1;
      rdvld  <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      if (flush) begin
        wrptr <= '0;
        rdptr <= '0;
      end else begin
        if (wrinc) wrptr <= ptr_inc(wrptr);
        if (rdinc) rdptr <= ptr_inc(rdptr);
      end
      count  <= count_nxt;
      wrrdy  <= (count_nxt != WC'(D));
      rdvld  <= (count_nxt != '0);
      afull  <= (count_nxt >= WC'(AFTH));
      aempty <= (count_nxt <= WC'(AETH));
    end
  end

  // Storage array; not reset, contents beyond the valid window are don't-care
  always_ff @(posedge clk) begin
    if (wrinc && !flush) mem[wrptr] <= wrdata;
  end

`ifdef POWLIB_LVLFIFO_PEAK_EN
  // High-watermark; a clear reloads with the occupancy being entered this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak <= '0;
    end else if (peakclr) begin
      peak <= count_nxt;
    end else if (count_nxt > peak) begin
      peak <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_powlib_lvlfifo.sv
// Scoreboard bench for powlib_lvlfifo (W=8, D=5, AFTH=3, AETH=2).
// Reference model: a queue of accepted words; occupancy and flags derive from its size.
module tb_powlib_lvlfifo;
  localparam int W    = 8;
  localparam int D    = 5;
  localparam int AFTH = 3;
  localparam int AETH = 2;
  localparam int WC   = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  wrdata = '0;
  logic          wrvld = 1'b0;
  logic          wrrdy;
  logic [W-1:0]  rddata;
  logic          rdvld;
  logic          rdrdy = 1'b0;
  logic          flush = 1'b0;
  logic [WC-1:0] count;
  logic          afull;
  logic          aempty;
`ifdef POWLIB_LVLFIFO_PEAK_EN
  logic [WC-1:0] peak;
  logic          peakclr = 1'b0;
`endif

  powlib_lvlfifo #(.W(W), .D(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .flush  (flush),
    .count  (count),
`ifdef POWLIB_LVLFIFO_PEAK_EN
    .afull  (afull),
    .aempty (aempty),
    .peak   (peak),
    .peakclr(peakclr)
`else
    .afull  (afull),
    .aempty (aempty)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb [$];
  int peak_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT against model state, then advances the model for the coming edge
  always @(negedge clk) begin
    int sz;
    int nsz;
    logic [W-1:0] exp_d;
    if (!rst) begin
      sb.delete();
      peak_m = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_wrrdy", 32'(wrrdy), 1);
      chk("rst_rdvld", 32'(rdvld), 0);
      chk("rst_afull", 32'(afull), 0);
      chk("rst_aempty", 32'(aempty), 1);
`ifdef POWLIB_LVLFIFO_PEAK_EN
      chk("rst_peak", 32'(peak), 0);
`endif
    end else begin
      sz = sb.size();
      chk("count", 32'(count), 32'(sz));
      chk("wrrdy", 32'(wrrdy), 32'(sz != D));
      chk("rdvld", 32'(rdvld), 32'(sz != 0));
      chk("afull", 32'(afull), 32'(sz >= AFTH));
      chk("aempty", 32'(aempty), 32'(sz <= AETH));
`ifdef POWLIB_LVLFIFO_PEAK_EN
      chk("peak", 32'(peak), 32'(peak_m));
`endif
      if (flush) begin
        sb.delete();
      end else begin
        if (rdrdy && sz > 0) begin
          exp_d = sb.pop_front();
          chk("rddata", 32'(rddata), 32'(exp_d));
        end
        if (wrvld && sz < D) sb.push_back(wrdata);
      end
      nsz = sb.size();
`ifdef POWLIB_LVLFIFO_PEAK_EN
      if (peakclr) peak_m = nsz;
      else if (nsz > peak_m) peak_m = nsz;
`endif
    end
  end

  task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr, input logic fl);
    wrvld  = wv;
    wrdata = wd;
    rdrdy  = rr;
    flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_steps(input int n, input int flush_pct);
    for (int i = 0; i < n; i++) begin
`ifdef POWLIB_LVLFIFO_PEAK_EN
      peakclr = ($urandom_range(15) == 0);
`endif
      step($urandom_range(1) == 1, W'($urandom), $urandom_range(1) == 1,
           int'($urandom_range(99)) < flush_pct);
    end
`ifdef POWLIB_LVLFIFO_PEAK_EN
    peakclr = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill 0x01..0x05, sixth write must be refused
    for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    // Drain in order
    repeat (7) step(1'b0, '0, 1'b1, 1'b0);

    // Wrap-around: 12 writes with reads at a 50% rate
    for (int i = 0; i < 12; i++) step(1'b1, W'($urandom), $urandom_range(1) == 1, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous write and read at count 3
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h31 + i), 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Flush at count 4 with a write presented; that word must never appear
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h41 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 8'h51, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

`ifdef POWLIB_LVLFIFO_PEAK_EN
    // Fill to 4, drain to 1, then clear the watermark
    step(1'b0, '0, 1'b0, 1'b1);
    peakclr = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    peakclr = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h61 + i), 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("peak_after_fill", 32'(peak), 4);
    peakclr = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    peakclr = 1'b0;
    chk("peak_after_clr", 32'(peak), 1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
`endif

    // Random traffic with occasional flush
    rnd_steps(300, 5);

    // Asynchronous reset mid-burst: outputs must return to reset values immediately
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h71 + i), 1'b0, 1'b0);
    wrvld = 1'b1;
    rdrdy = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_wrrdy", 32'(wrrdy), 1);
    chk("arst_rdvld", 32'(rdvld), 0);
    chk("arst_afull", 32'(afull), 0);
    chk("arst_aempty", 32'(aempty), 1);
`ifdef POWLIB_LVLFIFO_PEAK_EN
    chk("arst_peak", 32'(peak), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    // First edge after release must accept a write
    step(1'b1, 8'h99, 1'b0, 1'b0);
    rnd_steps(60, 0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/powlib_lvlfifo.md
POWLIB_LVLFIFO -- requirements
Module: powlib_lvlfifo

Interface
REQ-001 SHALL have parameter W, default 16: data width in bits, 1 or more.
REQ-002 SHALL have parameter D, default 8: depth in entries, 2 or more, any integer; power of 2 not required; all D entries usable.
REQ-003 SHALL have parameter AFTH, default D-2: almost-full threshold, 1 to D.
REQ-004 SHALL have parameter AETH, default 2: almost-empty threshold, 0 to D-1.
REQ-005 SHALL have parameter EDBG, default 0: nonzero enables simulation parameter checks.
REQ-006 SHALL have parameter ID, default "LVLFIFO": string identifier for debug messages.
REQ-007 SHALL define local WC = powlib_clogb2(D+1) and WP = powlib_clogb2(D).
REQ-008 Ports, clock and reset first:
- clk  in  1  the only clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wrdata  in  W  write data.
- wrvld  in  1  write valid.
- wrrdy  out  1  write ready.
- rddata  out  W  head-of-queue data.
- rdvld  out  1  read valid.
- rdrdy  in  1  read ready.
- flush  in  1  synchronous empty request.
- count  out  WC  occupancy, 0 to D.
- afull  out  1  count >= AFTH.
- aempty  out  1  count <= AETH.
- peak  out  WC  high-watermark; present only with POWLIB_LVLFIFO_PEAK_EN.
- peakclr  in  1  clears peak; present only with POWLIB_LVLFIFO_PEAK_EN.

Function
REQ-009 SHALL accept a write in a cycle exactly when wrvld and wrrdy are both 1 (wrinc), and SHALL accept a read in a cycle exactly when rdvld and rdrdy are both 1 (rdinc).
REQ-010 SHALL drive wrrdy = (count != D) and rdvld = (count != 0), both decoded from registered state.
REQ-011 SHALL be first-word-fall-through: rddata = mem[rdptr] combinationally; rddata is undefined when rdvld is 0.
REQ-012 SHALL make written data visible on rdvld/rddata the cycle after wrinc (latency 1).
REQ-013 SHALL advance wrptr and rdptr modulo D: value D-1 wraps to 0.
REQ-014 SHALL update count as +1 on wrinc only, -1 on rdinc only, and unchanged when wrinc and rdinc occur together or when neither occurs.
REQ-015 SHALL refuse a write when full even if a read occurs in the same cycle (no full-bypass).
REQ-016 SHALL not read when empty even if a write occurs in the same cycle (no empty-bypass).
REQ-017 SHALL register afull and aempty from next-count, so they change in the same cycle as count.
REQ-018 SHALL, on flush=1, set wrptr, rdptr and count to 0 at the next edge; flush overrides wrinc and rdinc, so data presented in that cycle is dropped; memory contents need not be cleared.
REQ-019 SHALL, when EDBG != 0, $display and $finish at time 0 if AFTH or AETH is out of range.

Reset
REQ-020 SHALL, on rst=0 and asynchronously, set wrptr=0, rdptr=0, count=0, wrrdy=1, rdvld=0, afull=(AFTH==0)=0 and aempty=1; with POWLIB_LVLFIFO_PEAK_EN, peak=0.
REQ-021 SHALL not reset memory contents.
REQ-022 SHALL accept no transfer while rst=0, and SHALL accept the first write on the first rising edge after rst deasserts.

Configuration
REQ-023 With macro POWLIB_LVLFIFO_PEAK_EN defined, SHALL provide peak and peakclr: peak registers the maximum count since reset or since the last peakclr; peakclr=1 loads peak with the next-count value; peakclr has priority over the max update.
REQ-024 Without POWLIB_LVLFIFO_PEAK_EN, SHALL omit peak, peakclr and their logic entirely; all other behaviour is identical.

Verification
REQ-025 Reset then fill, with W=8, D=5: write 0x01..0x05 with no reads -> wrrdy=0 after the fifth write; count=5; afull=1 from count=3; sixth write not accepted.
REQ-026 Drain after REQ-025: rdrdy=1 -> rddata reads 0x01..0x05 in order; rdvld=0 after 5 reads; aempty=1 once count<=2.
REQ-027 Wrap-around, D=5: 12 writes interleaved with reads at 50% rate -> output order is preserved across pointer wrap; count never exceeds 5.
REQ-028 Simultaneous transfer at count=3: wrinc and rdinc in the same cycle -> count stays 3; head advances; the new data is appended at the tail.
REQ-029 Flush at count=4 together with wrvld=1 -> next cycle count=0, rdvld=0, wrrdy=1; flushed-cycle data is never read.
REQ-030 With POWLIB_LVLFIFO_PEAK_EN, fill to 4, drain to 1 -> peak=4; peakclr pulse -> peak=1; asynchronous rst mid-burst -> all outputs return to the REQ-020 values immediately.
